// File: rtl/sh7034_int_seq_pkg.sv
// Shared types and constants for the SH7034 exception-entry sequencer.
package sh7034_int_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAccept,
        StPushSr,
        StPushPc,
        StVecRd,
        StLoad
    } IntSeqState_t;

    localparam logic [7:0]  NMI_VEC_DEF = 8'd11;
    localparam logic [31:0] WORD_MASK   = 32'hFFFF_FFFC;

    // Byte offset of a vector-table entry: four bytes per vector.
    function automatic logic [31:0] vec_offset(input logic [7:0] vec);
        return {22'd0, vec, 2'b00};
    endfunction

endpackage

// File: rtl/sh7034_bus_port.sv
// Single-access bus handshake: request, address and data hold until a no-wait CE cycle.
module sh7034_bus_port (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ce_i,
    input  logic        start_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_a_o,
    output logic [31:0] bus_do_o,
    input  logic [31:0] bus_di_i,
    input  logic        bus_wait_i
);

    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    assign done_o = ce_i & req_q & ~bus_wait_i;

    // A start in the completing cycle chains straight into the next access,
    // so the request line never drops between back-to-back transfers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (ce_i) begin
            if (done_o && !we_q) begin
                rdata_q <= bus_di_i;
            end
            if (start_i) begin
                req_q   <= 1'b1;
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end else if (done_o) begin
                req_q <= 1'b0;
            end
        end
    end

    assign rdata_o   = rdata_q;
    assign bus_req_o = req_q;
    assign bus_we_o  = we_q;
    assign bus_a_o   = addr_q;
    assign bus_do_o  = wdata_q;

endmodule

// File: rtl/sh7034_int_seq.sv
// SH7034 exception-entry sequencer: stacks SR/PC, fetches the vector, hands the new
// context to the CPU and acknowledges the interrupt controller.
module sh7034_int_seq
    import sh7034_int_seq_pkg::*;
#(
    parameter logic [7:0] NMI_VEC = NMI_VEC_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE,
    input  logic        INT_REQ,
    input  logic [3:0]  INT_LVL,
    input  logic [7:0]  INT_VEC,
    input  logic [3:0]  INT_MASK,
    output logic        INT_ACP,
    output logic        INT_ACK,
    input  logic        INST_BOUND,
    output logic        CPU_HOLD,
    input  logic [31:0] CPU_PC,
    input  logic [31:0] CPU_SR,
    input  logic [31:0] CPU_R15,
    input  logic [31:0] CPU_VBR,
    output logic        EXC_LOAD,
    output logic [31:0] EXC_PC,
    output logic [31:0] EXC_R15,
    output logic [3:0]  EXC_IMASK,
    output logic [31:0] BUS_A,
    output logic [31:0] BUS_DO,
    input  logic [31:0] BUS_DI,
    output logic        BUS_WE,
    output logic        BUS_REQ,
    input  logic        BUS_WAIT
);

    IntSeqState_t state_q, state_d;

    logic [3:0]  lvl_q;
    logic [7:0]  vec_q;
    logic [31:0] pc_q, sr_q, r15_q, vbr_q;
    logic [31:0] exc_r15_q;
    logic [3:0]  exc_imask_q;

    logic        accept;
    logic        start;
    logic        start_we;
    logic [31:0] start_addr;
    logic [31:0] start_data;
    logic        done;

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        start      = 1'b0;
        start_we   = 1'b0;
        start_addr = '0;
        start_data = '0;
        unique case (state_q)
            StIdle: begin
                if (INT_REQ && INST_BOUND && ((INT_VEC == NMI_VEC) || (INT_LVL > INT_MASK))) begin
                    accept  = 1'b1;
                    state_d = StAccept;
                end
            end
            StAccept: begin
                start      = 1'b1;
                start_we   = 1'b1;
                start_addr = (r15_q - 32'd4) & WORD_MASK;
                start_data = sr_q;
                state_d    = StPushSr;
            end
            StPushSr: begin
                if (done) begin
                    start      = 1'b1;
                    start_we   = 1'b1;
                    start_addr = (r15_q - 32'd8) & WORD_MASK;
                    start_data = pc_q;
                    state_d    = StPushPc;
                end
            end
            StPushPc: begin
                if (done) begin
                    start      = 1'b1;
                    start_addr = (vbr_q + vec_offset(vec_q)) & WORD_MASK;
                    state_d    = StVecRd;
                end
            end
            StVecRd: begin
                if (done) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            lvl_q       <= '0;
            vec_q       <= '0;
            pc_q        <= '0;
            sr_q        <= '0;
            r15_q       <= '0;
            vbr_q       <= '0;
            exc_r15_q   <= '0;
            exc_imask_q <= '0;
        end else if (CE) begin
            state_q <= state_d;
            if (accept) begin
                lvl_q <= INT_LVL;
                vec_q <= INT_VEC;
                pc_q  <= CPU_PC;
                sr_q  <= CPU_SR;
                r15_q <= CPU_R15;
                vbr_q <= CPU_VBR;
            end
            if (state_q == StVecRd && done) begin
                exc_r15_q   <= r15_q - 32'd8;
                exc_imask_q <= lvl_q;
            end
        end
    end

    sh7034_bus_port u_bus_port (
        .clk_i      (CLK),
        .rst_i      (RST),
        .ce_i       (CE),
        .start_i    (start),
        .we_i       (start_we),
        .addr_i     (start_addr),
        .wdata_i    (start_data),
        .done_o     (done),
        .rdata_o    (EXC_PC),
        .bus_req_o  (BUS_REQ),
        .bus_we_o   (BUS_WE),
        .bus_a_o    (BUS_A),
        .bus_do_o   (BUS_DO),
        .bus_di_i   (BUS_DI),
        .bus_wait_i (BUS_WAIT)
    );

    // Pulses are decoded from registered state, so they stretch across CE=0 cycles.
    assign INT_ACP   = (state_q == StAccept);
    assign EXC_LOAD  = (state_q == StLoad);
    assign INT_ACK   = (state_q == StLoad);
    assign CPU_HOLD  = (state_q != StIdle);
    assign EXC_R15   = exc_r15_q;
    assign EXC_IMASK = exc_imask_q;

endmodule

// File: tb/tb_sh7034_int_seq.sv
// Directed bench for sh7034_int_seq: bus scoreboard, latency and pulse checks.
module tb_sh7034_int_seq;

    logic        CLK = 1'b0;
    logic        RST, CE, INT_REQ, INST_BOUND, BUS_WAIT;
    logic [3:0]  INT_LVL, INT_MASK;
    logic [7:0]  INT_VEC;
    logic [31:0] CPU_PC, CPU_SR, CPU_R15, CPU_VBR;
    logic [31:0] BUS_DI;
    logic        INT_ACP, INT_ACK, CPU_HOLD, EXC_LOAD, BUS_WE, BUS_REQ;
    logic [31:0] EXC_PC, EXC_R15, BUS_A, BUS_DO;
    logic [3:0]  EXC_IMASK;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
    } xact_t;

    xact_t exp_q[$];

    int n_tests = 0, n_fail = 0;
    int acp_cnt = 0, ack_cnt = 0, load_cnt = 0;
    int nwait = 0, wait_left = 0, cyc = 0, exp_lat = 0;
    bit seq_active = 0, ce_mode = 0, drop_req = 0;
    logic [31:0] exp_pc, exp_r15;
    logic [3:0]  exp_imask;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return (a == 32'h0000_0200) ? 32'hABCD_0000 : ((a ^ 32'h5EED_0000) + 32'h13);
    endfunction

    assign BUS_DI = mem_rd(BUS_A);

    sh7034_int_seq dut (
        .CLK        (CLK),
        .RST        (RST),
        .CE         (CE),
        .INT_REQ    (INT_REQ),
        .INT_LVL    (INT_LVL),
        .INT_VEC    (INT_VEC),
        .INT_MASK   (INT_MASK),
        .INT_ACP    (INT_ACP),
        .INT_ACK    (INT_ACK),
        .INST_BOUND (INST_BOUND),
        .CPU_HOLD   (CPU_HOLD),
        .CPU_PC     (CPU_PC),
        .CPU_SR     (CPU_SR),
        .CPU_R15    (CPU_R15),
        .CPU_VBR    (CPU_VBR),
        .EXC_LOAD   (EXC_LOAD),
        .EXC_PC     (EXC_PC),
        .EXC_R15    (EXC_R15),
        .EXC_IMASK  (EXC_IMASK),
        .BUS_A      (BUS_A),
        .BUS_DO     (BUS_DO),
        .BUS_DI     (BUS_DI),
        .BUS_WE     (BUS_WE),
        .BUS_REQ    (BUS_REQ),
        .BUS_WAIT   (BUS_WAIT)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic we);
        xact_t t;
        t.a  = a;
        t.d  = d;
        t.we = we;
        exp_q.push_back(t);
    endtask

    // One clock: returns at the falling edge with outputs sampled and the
    // inputs for the next rising edge already driven.
    task automatic tick();
        bit ce_now;
        @(posedge CLK);
        @(negedge CLK);
        ce_now = ce_mode ? !CE : 1'b1;
        CE = ce_now;
        if (BUS_REQ) begin
            if (exp_q.size() == 0) begin
                chk("bus_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("bus_a", BUS_A, exp_q[0].a);
                chk("bus_we", 32'(BUS_WE), 32'(exp_q[0].we));
                if (exp_q[0].we) chk("bus_do", BUS_DO, exp_q[0].d);
            end
            BUS_WAIT = (wait_left != 0);
            if (ce_now) begin
                if (wait_left != 0) begin
                    wait_left--;
                end else begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    wait_left = nwait;
                end
            end
        end else begin
            BUS_WAIT = 1'b0;
        end
        if (ce_now) begin
            if (seq_active) cyc++;
            if (INT_ACP) begin
                acp_cnt++;
                if (!seq_active) begin
                    seq_active = 1;
                    cyc        = 1;
                    // Inputs are latched at acceptance; later changes must be ignored.
                    CPU_PC   = ~CPU_PC;
                    CPU_SR   = ~CPU_SR;
                    CPU_R15  = CPU_R15 + 32'h40;
                    CPU_VBR  = ~CPU_VBR;
                    INT_VEC  = ~INT_VEC;
                    INT_LVL  = ~INT_LVL;
                    INT_MASK = ~INT_MASK;
                end
            end
            if (INT_ACK) ack_cnt++;
            if (INT_ACK || EXC_LOAD) chk("ack_with_load", 32'(INT_ACK), 32'(EXC_LOAD));
            if (EXC_LOAD) begin
                load_cnt++;
                chk("latency", 32'(cyc), 32'(exp_lat));
                chk("exc_pc", EXC_PC, exp_pc);
                chk("exc_r15", EXC_R15, exp_r15);
                chk("exc_imask", 32'(EXC_IMASK), 32'(exp_imask));
                seq_active = 0;
                INT_REQ    = 1'b0;
            end
            if (seq_active && cyc == 2 && drop_req) INT_REQ = 1'b0;
        end
    endtask

    task automatic run_seq(input logic [3:0] lvl, input logic [7:0] vec, input logic [3:0] mask,
                           input logic [31:0] pc, input logic [31:0] sr, input logic [31:0] r15,
                           input logic [31:0] vbr, input int nw, input int bound_delay,
                           input bit drop);
        int acp0 = acp_cnt, ack0 = ack_cnt, ld0 = load_cnt;
        logic [31:0] vaddr;
        vaddr = (vbr + {22'd0, vec, 2'b00}) & 32'hFFFF_FFFC;
        exp_q.delete();
        nwait     = nw;
        wait_left = nw;
        push((r15 - 32'd4) & 32'hFFFF_FFFC, sr, 1'b1);
        push((r15 - 32'd8) & 32'hFFFF_FFFC, pc, 1'b1);
        push(vaddr, 32'd0, 1'b0);
        exp_pc     = mem_rd(vaddr);
        exp_r15    = r15 - 32'd8;
        exp_imask  = lvl;
        exp_lat    = 5 + 3 * nw;
        drop_req   = drop;
        CPU_PC     = pc;
        CPU_SR     = sr;
        CPU_R15    = r15;
        CPU_VBR    = vbr;
        INT_LVL    = lvl;
        INT_VEC    = vec;
        INT_MASK   = mask;
        INST_BOUND = (bound_delay == 0);
        INT_REQ    = 1'b1;
        if (bound_delay != 0) begin
            repeat (bound_delay) tick();
            chk("no_acp_unbound", 32'(acp_cnt - acp0), 32'd0);
            chk("no_hold_unbound", 32'(CPU_HOLD), 32'd0);
            INST_BOUND = 1'b1;
        end
        for (int i = 0; i < 120 && load_cnt == ld0; i++) tick();
        chk("load_seen", 32'(load_cnt - ld0), 32'd1);
        INT_REQ = 1'b0;
        repeat (3) tick();
        chk("acp_once", 32'(acp_cnt - acp0), 32'd1);
        chk("ack_once", 32'(ack_cnt - ack0), 32'd1);
        chk("bus_all_done", 32'(exp_q.size()), 32'd0);
        chk("hold_released", 32'(CPU_HOLD), 32'd0);
        drop_req   = 0;
        seq_active = 0;
    endtask

    initial begin
        int acp0, ack0, ld0;
        RST = 1'b1; CE = 1'b1; INT_REQ = 1'b0; INST_BOUND = 1'b1; BUS_WAIT = 1'b0;
        INT_LVL = '0; INT_MASK = '0; INT_VEC = '0;
        CPU_PC = '0; CPU_SR = '0; CPU_R15 = '0; CPU_VBR = '0;
        tick();
        tick();
        chk("rst_hold", 32'(CPU_HOLD), 32'd0);
        chk("rst_acp", 32'(INT_ACP), 32'd0);
        chk("rst_ack", 32'(INT_ACK), 32'd0);
        chk("rst_load", 32'(EXC_LOAD), 32'd0);
        chk("rst_req", 32'(BUS_REQ), 32'd0);
        chk("rst_we", 32'(BUS_WE), 32'd0);
        chk("rst_a", BUS_A, 32'd0);
        chk("rst_do", BUS_DO, 32'd0);
        chk("rst_exc_pc", EXC_PC, 32'd0);
        chk("rst_exc_r15", EXC_R15, 32'd0);
        chk("rst_exc_imask", 32'(EXC_IMASK), 32'd0);
        RST = 1'b0;
        tick();

        // Plain IRQ, zero wait.
        run_seq(4'd5, 8'd64, 4'd3, 32'h1234, 32'h30, 32'h0000_F000, 32'h100, 0, 0, 0);

        // Level equal to mask is not accepted.
        INT_LVL = 4'd3; INT_MASK = 4'd3; INT_VEC = 8'd64; INST_BOUND = 1'b1; INT_REQ = 1'b1;
        acp0 = acp_cnt;
        repeat (6) begin
            tick();
            chk("masked_hold", 32'(CPU_HOLD), 32'd0);
        end
        chk("masked_acp", 32'(acp_cnt - acp0), 32'd0);
        INT_REQ = 1'b0;
        tick();

        // NMI passes a fully closed mask.
        run_seq(4'hF, 8'd11, 4'hF, 32'h2000_0010, 32'hF0, 32'h0000_8000, 32'h1000, 0, 0, 0);

        // Three wait states on every access.
        run_seq(4'd9, 8'd20, 4'd2, 32'hCAFE_0000, 32'h1F3, 32'h0010_0000, 32'h400, 3, 0, 0);

        // CE every other clock.
        ce_mode = 1;
        run_seq(4'd5, 8'd64, 4'd3, 32'h1234, 32'h30, 32'h0000_F000, 32'h100, 0, 0, 0);
        run_seq(4'd6, 8'd33, 4'd1, 32'h0000_5678, 32'h71, 32'h0000_A004, 32'h800, 1, 0, 0);
        ce_mode = 0;
        CE = 1'b1;
        tick();

        // Stack and vector address wrap.
        run_seq(4'd8, 8'd255, 4'd0, 32'h0000_0ABC, 32'h0E0, 32'h0, 32'hFFFF_FF00, 0, 0, 0);

        // Held off by INST_BOUND, then request dropped during PUSH_SR.
        run_seq(4'd4, 8'd70, 4'd1, 32'h0000_4444, 32'h40, 32'h0000_3000, 32'h200, 0, 4, 0);
        run_seq(4'd7, 8'd80, 4'd0, 32'h0000_8888, 32'h70, 32'h0000_2000, 32'h300, 1, 0, 1);

        // Reset while the vector read is stalled.
        exp_q.delete();
        nwait = 3; wait_left = 3;
        push(32'h0000_7FFC, 32'h22, 1'b1);
        push(32'h0000_7FF8, 32'h9999, 1'b1);
        push(32'h0000_0440, 32'd0, 1'b0);
        exp_lat = 14; exp_pc = mem_rd(32'h440); exp_r15 = 32'h7FF8; exp_imask = 4'd7;
        CPU_PC = 32'h9999; CPU_SR = 32'h22; CPU_R15 = 32'h8000; CPU_VBR = 32'h400;
        INT_LVL = 4'd7; INT_VEC = 8'h10; INT_MASK = 4'd0; INST_BOUND = 1'b1; INT_REQ = 1'b1;
        for (int i = 0; i < 60 && !(BUS_REQ && !BUS_WE); i++) tick();
        chk("rd_reached", 32'(BUS_REQ && !BUS_WE), 32'd1);
        ld0 = load_cnt; ack0 = ack_cnt;
        RST = 1'b1;
        INT_REQ = 1'b0;
        tick();
        chk("midrst_req", 32'(BUS_REQ), 32'd0);
        chk("midrst_hold", 32'(CPU_HOLD), 32'd0);
        chk("midrst_load", 32'(EXC_LOAD), 32'd0);
        chk("midrst_ack", 32'(INT_ACK), 32'd0);
        RST = 1'b0;
        exp_q.delete();
        seq_active = 0;
        repeat (3) tick();
        chk("midrst_no_load", 32'(load_cnt - ld0), 32'd0);
        chk("midrst_no_ack", 32'(ack_cnt - ack0), 32'd0);

        // Fresh request after the abort.
        run_seq(4'd5, 8'd64, 4'd3, 32'h1234, 32'h30, 32'h0000_F000, 32'h100, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
